signed_minmax_tracker: RTL and testbench
========================================

Name: signed_minmax_tracker

Overview:
- Streaming consumer of the 16-bit signed compare function. Takes a stream of two's-complement samples over a valid/ready handshake.
- Tracks the running maximum and minimum, and the index of each, over fixed-length frames.
- Presents one result record per frame on a valid/ready output.
- Sits directly downstream of the signed comparator stage: each accepted sample is compared against the held max and the held min, using greater/less/equal semantics.

Parameters:
- FRAME_LEN, 8, samples per frame; legal range 2..256.
- IDX_W, 8, width of the index outputs; must satisfy 2^IDX_W >= FRAME_LEN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- in_data  in  16  two's-complement sample.
- flush  in  1  synchronous abort of the current frame.
- out_valid  out  1  frame result present.
- out_ready  in  1  downstream accepts the result.
- out_max  out  16  largest sample of the frame (signed).
- out_min  out  16  smallest sample of the frame (signed).
- out_max_idx  out  IDX_W  position of the first occurrence of the max (0-based).
- out_min_idx  out  IDX_W  position of the first occurrence of the min (0-based).
- out_all_eq  out  1  every sample in the frame equalled sample 0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE.
  - in_ready=0 while reset is asserted; in_ready=1 from the first clock after release.
  - out_valid=0, out_max=0, out_min=0, out_max_idx=0, out_min_idx=0, out_all_eq=0.
  - Internal count=0.
- A sample is accepted on a clock edge when in_valid & in_ready. A result is consumed when out_valid & out_ready.
- Compare semantics: full 16-bit two's-complement ordering. 16'h8000 = -32768 is the smallest value; 16'h7FFF = +32767 is the largest.
- State IDLE (in_ready=1):
  - On accept: max=min=in_data, max_idx=min_idx=0, all_eq=1, count=1, go to ACCUM.
- State ACCUM (in_ready=1):
  - On accept, with A=in_data, B=held max: if A>B strictly, max<=A and max_idx<=count.
  - Same with B=held min: if A<B strictly, min<=A and min_idx<=count.
  - Ties never update, so the first occurrence wins.
  - all_eq<=all_eq & (in_data==first sample). The first sample is held in its own register.
  - count<=count+1.
  - When the accepted sample is number FRAME_LEN (count==FRAME_LEN-1 before increment):
    - Load the output registers with the final values, including this sample's update.
    - Set out_valid=1, count<=0, go to HOLD.
- State HOLD (in_ready=0):
  - Outputs are stable while out_valid=1 and out_ready=0.
  - On consume: out_valid<=0, go to IDLE.
  - in_ready depends only on state; there is no combinational path from out_ready to in_ready.
- Latency:
  - Last sample accepted at edge t gives out_valid=1 after edge t (visible in cycle t+1).
  - Minimum frame period is FRAME_LEN+1 cycles when out_ready is tied high.
- Output registers update only on the HOLD entry edge. Between frames they keep their last values; out_valid alone qualifies them.
- flush=1 in IDLE or ACCUM:
  - Discards the partial frame; any sample offered that cycle is not accepted (in_ready forced 0 that cycle).
  - count<=0, go to IDLE.
- flush=1 in HOLD: ignored. A completed result is never dropped.
- in_valid with in_data changing while in_ready=0: the data is ignored and no state changes.
- Reset mid-frame or mid-HOLD: immediate return to reset values; the pending result is lost.
- count is IDX_W+1 bits wide and never exceeds FRAME_LEN-1, so it does not wrap.

Test Plan:
- FRAME_LEN=4, out_ready=1, samples 5, -3, 7, -3 → out_max=7, idx 2; out_min=-3 (16'hFFFD), idx 1; out_all_eq=0; out_valid high exactly 1 cycle, one cycle after the 4th accept.
- Sign boundary: samples 16'h7FFF, 16'h8000, 0, 16'hFFFF → max=16'h7FFF idx 0, min=16'h8000 idx 1. A wrong (unsigned or sign-inverted) comparator must fail this check.
- Equal stream: four samples of 16'h1234 → max=min=16'h1234, both idx 0, out_all_eq=1.
- Backpressure: complete a frame, hold out_ready=0 for 5 cycles while in_valid=1 → in_ready=0 and outputs stable throughout; raise out_ready → consumed, in_ready=1 next cycle, and the next frame starts from idx 0.
- Flush: accept 2 samples, pulse flush with in_valid=1 → that sample is not accepted; the following 4 samples 1, 2, 3, 4 give max=4 idx 3, min=1 idx 0.
- Reset in ACCUM after 3 samples with rst_n asynchronous low mid-cycle → outputs go to 0 immediately, in_ready=0 while asserted; after release a full new frame produces a correct result.

Source files
------------

// File: rtl/signed_minmax_tracker.sv
// signed_minmax_tracker: frame-based running signed max/min tracker.
// Accepts 16-bit two's-complement samples over valid/ready and tracks, per frame
// of FRAME_LEN samples, the max, the min, the first index of each, and whether
// every sample equalled the first one. One result record is held per frame.
module signed_minmax_tracker #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_max,
  output logic [15:0]      out_min,
  output logic [IDX_W-1:0] out_max_idx,
  output logic [IDX_W-1:0] out_min_idx,
  output logic             out_all_eq
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t             state;
  logic               started;
  logic [CNT_W-1:0]   count;
  logic [15:0]        max_q;
  logic [15:0]        min_q;
  logic [15:0]        first_q;
  logic [IDX_W-1:0]   max_idx_q;
  logic [IDX_W-1:0]   min_idx_q;
  logic               all_eq_q;

  logic               accept;
  logic               last;
  logic               gt_max;
  logic               lt_min;
  logic [15:0]        nxt_max;
  logic [15:0]        nxt_min;
  logic [IDX_W-1:0]   nxt_max_idx;
  logic [IDX_W-1:0]   nxt_min_idx;
  logic               nxt_all_eq;

  // in_ready is a function of state only (plus the flush override); started
  // keeps it low through reset and until the first clock after release.
  assign in_ready = started && (state != HOLD) && !flush;
  assign accept   = in_valid && in_ready;
  assign last     = (count == CNT_W'(FRAME_LEN - 1));
  assign gt_max   = $signed(in_data) > $signed(max_q);
  assign lt_min   = $signed(in_data) < $signed(min_q);

  // Running values after folding in the current sample; ties keep the old index.
  always_comb begin
    nxt_max     = max_q;
    nxt_min     = min_q;
    nxt_max_idx = max_idx_q;
    nxt_min_idx = min_idx_q;
    nxt_all_eq  = all_eq_q;
    if (state == IDLE) begin
      nxt_max     = in_data;
      nxt_min     = in_data;
      nxt_max_idx = '0;
      nxt_min_idx = '0;
      nxt_all_eq  = 1'b1;
    end else begin
      if (gt_max) begin
        nxt_max     = in_data;
        nxt_max_idx = count[IDX_W-1:0];
      end
      if (lt_min) begin
        nxt_min     = in_data;
        nxt_min_idx = count[IDX_W-1:0];
      end
      nxt_all_eq = all_eq_q && (in_data == first_q);
    end
  end

  // Frame state machine, working registers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      started     <= 1'b0;
      count       <= '0;
      max_q       <= '0;
      min_q       <= '0;
      first_q     <= '0;
      max_idx_q   <= '0;
      min_idx_q   <= '0;
      all_eq_q    <= 1'b0;
      out_valid   <= 1'b0;
      out_max     <= '0;
      out_min     <= '0;
      out_max_idx <= '0;
      out_min_idx <= '0;
      out_all_eq  <= 1'b0;
    end else begin
      started <= 1'b1;
      if (flush && (state != HOLD)) begin
        count <= '0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              max_q     <= nxt_max;
              min_q     <= nxt_min;
              max_idx_q <= nxt_max_idx;
              min_idx_q <= nxt_min_idx;
              all_eq_q  <= nxt_all_eq;
              first_q   <= in_data;
              count     <= CNT_W'(1);
              state     <= ACCUM;
            end
          end
          ACCUM: begin
            if (accept) begin
              max_q     <= nxt_max;
              min_q     <= nxt_min;
              max_idx_q <= nxt_max_idx;
              min_idx_q <= nxt_min_idx;
              all_eq_q  <= nxt_all_eq;
              if (last) begin
                out_max     <= nxt_max;
                out_min     <= nxt_min;
                out_max_idx <= nxt_max_idx;
                out_min_idx <= nxt_min_idx;
                out_all_eq  <= nxt_all_eq;
                out_valid   <= 1'b1;
                count       <= '0;
                state       <= HOLD;
              end else begin
                count <= count + CNT_W'(1);
              end
            end
          end
          HOLD: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Testbench for signed_minmax_tracker with FRAME_LEN=4: directed cases plus
// randomized frames checked against a whole-frame reference model.
module tb_signed_minmax_tracker;

  localparam int unsigned FL = 4;
  localparam int unsigned IW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_max;
  logic [15:0]   out_min;
  logic [IW-1:0] out_max_idx;
  logic [IW-1:0] out_min_idx;
  logic          out_all_eq;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] frm [FL];
  logic [15:0] e_max;
  logic [15:0] e_min;
  int          e_maxi;
  int          e_mini;
  logic        e_eq;

  signed_minmax_tracker #(.FRAME_LEN(FL), .IDX_W(IW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_max(out_max),
    .out_min(out_min),
    .out_max_idx(out_max_idx),
    .out_min_idx(out_min_idx),
    .out_all_eq(out_all_eq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: find the extreme values of the whole frame, then the earliest
  // position holding each; the frame is all-equal exactly when max == min.
  task automatic model();
    int mx;
    int mn;
    int v;
    mx = -40000;
    mn = 40000;
    for (int i = 0; i < int'(FL); i++) begin
      v = int'($signed(frm[i]));
      if (v > mx) mx = v;
      if (v < mn) mn = v;
    end
    e_maxi = -1;
    e_mini = -1;
    for (int i = int'(FL) - 1; i >= 0; i--) begin
      v = int'($signed(frm[i]));
      if (v == mx) e_maxi = i;
      if (v == mn) e_mini = i;
    end
    e_max = 16'(mx);
    e_min = 16'(mn);
    e_eq  = (mx == mn);
  endtask

  task automatic check_fields(input string pfx);
    chk({pfx, ".valid"},  32'(out_valid),   32'd1);
    chk({pfx, ".max"},    32'(out_max),     32'(e_max));
    chk({pfx, ".min"},    32'(out_min),     32'(e_min));
    chk({pfx, ".maxidx"}, 32'(out_max_idx), e_maxi);
    chk({pfx, ".minidx"}, 32'(out_min_idx), e_mini);
    chk({pfx, ".alleq"},  32'(out_all_eq),  32'(e_eq));
  endtask

  // Offers the FL samples of frm back to back, then checks the result one
  // cycle after the last accept.
  task automatic send_frame(input string pfx);
    for (int i = 0; i < int'(FL); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frm[i];
      chk({pfx, ".rdy"}, 32'(in_ready), 32'd1);
      if (i == int'(FL) - 1) chk({pfx, ".early"}, 32'(out_valid), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    model();
    check_fields(pfx);
  endtask

  task automatic consume(input string pfx);
    @(posedge clk);
    @(negedge clk);
    chk({pfx, ".gone"},   32'(out_valid), 32'd0);
    chk({pfx, ".rdynxt"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    logic [15:0] extremes [4];
    logic [15:0] base;
    int unsigned mode;

    extremes[0] = 16'h8000;
    extremes[1] = 16'h7FFF;
    extremes[2] = 16'h0000;
    extremes[3] = 16'hFFFF;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset values
    #1;
    chk("rst.rdy",    32'(in_ready),    32'd0);
    chk("rst.valid",  32'(out_valid),   32'd0);
    chk("rst.max",    32'(out_max),     32'd0);
    chk("rst.min",    32'(out_min),     32'd0);
    chk("rst.maxidx", 32'(out_max_idx), 32'd0);
    chk("rst.minidx", 32'(out_min_idx), 32'd0);
    chk("rst.alleq",  32'(out_all_eq),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.rdy0", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rel.rdy1", 32'(in_ready), 32'd1);

    // Basic frame 5, -3, 7, -3
    frm[0] = 16'd5; frm[1] = 16'hFFFD; frm[2] = 16'd7; frm[3] = 16'hFFFD;
    send_frame("basic");
    chk("basic.max_k", 32'(out_max), 32'd7);
    chk("basic.min_k", 32'(out_min), 32'h0000FFFD);
    consume("basic");

    // Sign boundary
    frm[0] = 16'h7FFF; frm[1] = 16'h8000; frm[2] = 16'h0000; frm[3] = 16'hFFFF;
    send_frame("sign");
    chk("sign.max_k", 32'(out_max), 32'h00007FFF);
    chk("sign.min_k", 32'(out_min), 32'h00008000);
    consume("sign");

    // Equal stream
    for (int i = 0; i < int'(FL); i++) frm[i] = 16'h1234;
    send_frame("eq");
    chk("eq.alleq_k", 32'(out_all_eq), 32'd1);
    consume("eq");

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    frm[0] = 16'd3; frm[1] = 16'hFF00; frm[2] = 16'd300; frm[3] = 16'd300;
    send_frame("bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'(16'h4000 + c);
      #1;
      chk("bp.rdy0",  32'(in_ready),    32'd0);
      chk("bp.valid", 32'(out_valid),   32'd1);
      chk("bp.max",   32'(out_max),     32'(e_max));
      chk("bp.min",   32'(out_min),     32'(e_min));
      chk("bp.maxi",  32'(out_max_idx), e_maxi);
      chk("bp.mini",  32'(out_min_idx), e_mini);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    consume("bp");
    frm[0] = 16'd100; frm[1] = 16'd1; frm[2] = 16'd2; frm[3] = 16'hFFFB;
    send_frame("bpnext");
    consume("bpnext");

    // Flush mid-frame
    @(negedge clk); in_valid = 1'b1; in_data = 16'd9;      @(posedge clk);
    @(negedge clk); in_valid = 1'b1; in_data = 16'hFFF7;   @(posedge clk);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd1000;
    #1;
    chk("flush.rdy0", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    frm[0] = 16'd1; frm[1] = 16'd2; frm[2] = 16'd3; frm[3] = 16'd4;
    send_frame("flush");
    chk("flush.maxi_k", 32'(out_max_idx), 32'd3);
    consume("flush");

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'(16'd50 + i);
      @(posedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.max",   32'(out_max),     32'd0);
    chk("arst.min",   32'(out_min),     32'd0);
    chk("arst.maxi",  32'(out_max_idx), 32'd0);
    chk("arst.valid", 32'(out_valid),   32'd0);
    chk("arst.rdy",   32'(in_ready),    32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst.rdy1", 32'(in_ready), 32'd1);
    frm[0] = 16'hFFF0; frm[1] = 16'd20; frm[2] = 16'hFFF0; frm[3] = 16'd20;
    send_frame("arst");
    consume("arst");

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      mode = $urandom_range(0, 3);
      base = 16'($urandom);
      for (int i = 0; i < int'(FL); i++) begin
        case (mode)
          0:       frm[i] = 16'($urandom);
          1:       frm[i] = 16'(int'($urandom_range(0, 4)) - 2);
          2:       frm[i] = base;
          default: frm[i] = extremes[$urandom_range(0, 3)];
        endcase
      end
      send_frame("rnd");
      consume("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
